// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ datapath: sequencer state encoding, the
// sample record handed to the FIFO, default widths and small helpers.
package daq_pkg;

    localparam int DEF_NUM_CHANNELS    = 16;
    localparam int DEF_ADC_WIDTH       = 12;
    localparam int DEF_CHANNEL_WIDTH   = 4;
    localparam int DEF_TIMESTAMP_WIDTH = 32;
    localparam int DEF_SETTLE_CYCLES   = 2;
    localparam int DEF_TIMEOUT_CYCLES  = 64;
    localparam int DEF_AVG_LOG2        = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        OUTPUT    = 3'd4
    } seq_state_e;

    // One captured sample as stored by the FIFO.
    typedef struct packed {
        logic [DEF_ADC_WIDTH-1:0]       data;
        logic [DEF_CHANNEL_WIDTH-1:0]   channel;
        logic [DEF_TIMESTAMP_WIDTH-1:0] timestamp;
    } daq_sample_t;

    // Increment an 8-bit counter, holding at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// Grant (arbiter -> sequencer) and sample (sequencer -> FIFO) handshakes.
// The master modport is the sequencer's view; slave is its surroundings.
interface adc_conv_sequencer_if #(
    parameter int CHANNEL_WIDTH   = 4,
    parameter int ADC_WIDTH       = 12,
    parameter int TIMESTAMP_WIDTH = 32
);
    logic                       req_valid;
    logic [CHANNEL_WIDTH-1:0]   req_channel;
    logic                       req_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [ADC_WIDTH-1:0]       out_data;
    logic [CHANNEL_WIDTH-1:0]   out_channel;
    logic [TIMESTAMP_WIDTH-1:0] out_timestamp;

    modport master (
        input  req_valid, req_channel, out_ready,
        output req_ready, out_valid, out_data, out_channel, out_timestamp
    );

    modport slave (
        output req_valid, req_channel, out_ready,
        input  req_ready, out_valid, out_data, out_channel, out_timestamp
    );
endinterface

// File: rtl/seq_timeout_timer.sv
// Loadable down-counter that stops at zero; expired is high while the count
// is zero. Used for both the settle delay and the conversion timeout.
module seq_timeout_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_r;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: takes one arbiter grant at a time, selects the
// channel, waits the settle time, pulses start, waits for done (with a
// timeout) and hands the timestamped result to the sample FIFO.
// Optional build macro ADC_SEQ_AVG_EN: average 2^AVG_LOG2 conversions/grant.
module adc_conv_sequencer
    import daq_pkg::*;
#(
    parameter int NUM_CHANNELS    = 16,
    parameter int ADC_WIDTH       = 12,
    parameter int CHANNEL_WIDTH   = 4,
    parameter int TIMESTAMP_WIDTH = 32,
    parameter int SETTLE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int AVG_LOG2        = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    adc_conv_sequencer_if.master     bus,
    output logic                     adc_start_conv,
    output logic [CHANNEL_WIDTH-1:0] adc_channel_sel,
    input  logic                     adc_busy,
    input  logic                     adc_conv_done,
    input  logic [ADC_WIDTH-1:0]     adc_data,
    output logic                     timeout_err,
    output logic [7:0]               err_count,
    output logic                     seq_busy
);

    localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    seq_state_e                 state_r;
    seq_state_e                 state_n;
    logic [TIMESTAMP_WIDTH-1:0] ts_r;
    logic [CHANNEL_WIDTH-1:0]   ch_r;
    logic                       start_conv_r;
    logic                       out_valid_r;
    logic [ADC_WIDTH-1:0]       out_data_r;
    logic [CHANNEL_WIDTH-1:0]   out_channel_r;
    logic [TIMESTAMP_WIDTH-1:0] out_ts_r;
    logic                       timeout_err_r;
    logic [7:0]                 err_count_r;
    logic                       seq_busy_r;

    logic                       req_ready_s;
    logic                       grant_s;
    logic                       done_s;
    logic                       timeout_s;
    logic                       last_conv_s;
    logic                       tmr_load_s;
    logic [TMR_W-1:0]           tmr_val_s;
    logic                       tmr_expired_s;
    logic [ADC_WIDTH-1:0]       capture_data_s;
    logic [TIMESTAMP_WIDTH-1:0] capture_ts_s;

    seq_timeout_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .expired  (tmr_expired_s)
    );

    // New grants are only taken from IDLE with the system enabled and ADC free.
    assign req_ready_s = enable && !adc_busy && (state_r == IDLE);

`ifdef ADC_SEQ_AVG_EN
    localparam int ACC_WIDTH = ADC_WIDTH + AVG_LOG2;
    localparam int IDX_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [ACC_WIDTH-1:0]       acc_r;
    logic [ACC_WIDTH-1:0]       acc_sum_s;
    logic [IDX_W-1:0]           conv_idx_r;
    logic [TIMESTAMP_WIDTH-1:0] first_ts_r;

    assign acc_sum_s      = acc_r + ACC_WIDTH'(adc_data);
    assign last_conv_s    = (AVG_LOG2 == 0) ? 1'b1 : (conv_idx_r == {IDX_W{1'b1}});
    assign capture_data_s = ADC_WIDTH'(acc_sum_s >> AVG_LOG2);
    assign capture_ts_s   = (conv_idx_r == {IDX_W{1'b0}}) ? ts_r : first_ts_r;

    // Accumulate the conversions of one grant; timestamp comes from the first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            conv_idx_r <= {IDX_W{1'b0}};
            first_ts_r <= {TIMESTAMP_WIDTH{1'b0}};
        end else if (grant_s) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            conv_idx_r <= {IDX_W{1'b0}};
        end else if (done_s) begin
            acc_r      <= acc_sum_s;
            conv_idx_r <= conv_idx_r + IDX_W'(1);
            if (conv_idx_r == {IDX_W{1'b0}}) begin
                first_ts_r <= ts_r;
            end
        end
    end
`else
    assign last_conv_s    = 1'b1;
    assign capture_data_s = adc_data;
    assign capture_ts_s   = ts_r;
`endif

    // Next-state, timer control and event decode for the sequencing FSM.
    always_comb begin
        state_n    = state_r;
        grant_s    = 1'b0;
        done_s     = 1'b0;
        timeout_s  = 1'b0;
        tmr_load_s = 1'b0;
        tmr_val_s  = {TMR_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (bus.req_valid && req_ready_s) begin
                    grant_s = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        state_n = START;
                    end else begin
                        state_n    = SETTLE;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = SETTLE_LOAD;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SETTLE: begin
                if (tmr_expired_s) begin
                    state_n = START;
                end else begin
                    state_n = SETTLE;
                end
            end
            START: begin
                state_n    = WAIT_DONE;
                tmr_load_s = 1'b1;
                tmr_val_s  = TIMEOUT_LOAD;
            end
            WAIT_DONE: begin
                // A done arriving on the last timeout cycle still counts.
                if (adc_conv_done) begin
                    done_s = 1'b1;
                    if (last_conv_s) begin
                        state_n = OUTPUT;
                    end else begin
                        state_n = START;
                    end
                end else if (tmr_expired_s) begin
                    timeout_s = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n = WAIT_DONE;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = OUTPUT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Free-running timestamp, independent of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r <= {TIMESTAMP_WIDTH{1'b0}};
        end else begin
            ts_r <= ts_r + TIMESTAMP_WIDTH'(1);
        end
    end

    // State register and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            ch_r          <= {CHANNEL_WIDTH{1'b0}};
            start_conv_r  <= 1'b0;
            out_valid_r   <= 1'b0;
            seq_busy_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            err_count_r   <= 8'd0;
        end else begin
            state_r       <= state_n;
            start_conv_r  <= (state_n == START);
            out_valid_r   <= (state_n == OUTPUT);
            seq_busy_r    <= (state_n != IDLE);
            timeout_err_r <= timeout_s;
            if (grant_s) begin
                ch_r <= bus.req_channel;
            end
            if (timeout_s) begin
                err_count_r <= sat_inc8(err_count_r);
            end
        end
    end

    // Sample capture; held unchanged through any FIFO backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r    <= {ADC_WIDTH{1'b0}};
            out_channel_r <= {CHANNEL_WIDTH{1'b0}};
            out_ts_r      <= {TIMESTAMP_WIDTH{1'b0}};
        end else if (done_s && last_conv_s) begin
            out_data_r    <= capture_data_s;
            out_channel_r <= ch_r;
            out_ts_r      <= capture_ts_s;
        end
    end

    assign bus.req_ready     = req_ready_s;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_data      = out_data_r;
    assign bus.out_channel   = out_channel_r;
    assign bus.out_timestamp = out_ts_r;
    assign adc_start_conv    = start_conv_r;
    assign adc_channel_sel   = ch_r;
    assign timeout_err       = timeout_err_r;
    assign err_count         = err_count_r;
    assign seq_busy          = seq_busy_r;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Self-checking bench for adc_conv_sequencer: table of grant/response
// vectors with a sample scoreboard, plus timeout, gating and reset sequences.
module tb_adc_conv_sequencer;
    import daq_pkg::*;

    localparam int CW = 4;
    localparam int AW = 12;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          adc_busy = 1'b0;
    logic          adc_conv_done = 1'b0;
    logic [AW-1:0] adc_data = '0;
    logic          adc_start_conv;
    logic [CW-1:0] adc_channel_sel;
    logic          timeout_err;
    logic [7:0]    err_count;
    logic          seq_busy;

    adc_conv_sequencer_if #(.CHANNEL_WIDTH(CW), .ADC_WIDTH(AW), .TIMESTAMP_WIDTH(TW)) bus ();

    adc_conv_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .bus             (bus),
        .adc_start_conv  (adc_start_conv),
        .adc_channel_sel (adc_channel_sel),
        .adc_busy        (adc_busy),
        .adc_conv_done   (adc_conv_done),
        .adc_data        (adc_data),
        .timeout_err     (timeout_err),
        .err_count       (err_count),
        .seq_busy        (seq_busy)
    );

    always #5 clk = ~clk;

    // Reference timestamp: counts clocks since reset release.
    logic [TW-1:0] m_ts;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_ts <= '0;
        else        m_ts <= m_ts + 32'd1;
    end

    typedef struct {
        logic [AW-1:0] data;
        logic [CW-1:0] ch;
        logic [TW-1:0] ts;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [CW-1:0] ch;
        int            delay;
        logic [AW-1:0] data;
        int            hold;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a grant at the current negedge and check the start pulse at T+3.
    task automatic grant_start(input logic [CW-1:0] ch);
        bus.req_valid   = 1'b1;
        bus.req_channel = ch;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("chsel_t1", 64'(adc_channel_sel), 64'(ch));
        chk("no_start_t1", 64'(adc_start_conv), 64'd0);
        tick();
        chk("no_start_t2", 64'(adc_start_conv), 64'd0);
        tick();
        chk("start_t3", 64'(adc_start_conv), 64'd1);
        chk("chsel_t3", 64'(adc_channel_sel), 64'(ch));
    endtask

    // From the start-pulse cycle, answer 'delay' cycles later with 'data'.
    task automatic respond(input int delay, input logic [AW-1:0] data,
                           input logic [CW-1:0] ch, output logic [TW-1:0] ts_done);
        logic bad;
        bad = 1'b0;
        ts_done = '0;
        for (int i = 1; i <= delay; i++) begin
            tick();
            if (adc_start_conv || timeout_err || bus.out_valid || (adc_channel_sel != ch) || !seq_busy)
                bad = 1'b1;
            if (i == delay) begin
                adc_conv_done = 1'b1;
                adc_data      = data;
                ts_done       = m_ts;
            end
        end
        tick();
        adc_conv_done = 1'b0;
        adc_data      = '0;
        chk("wait_done_quiet", 64'(bad), 64'd0);
    endtask

    // Hold back the FIFO for 'hold' cycles, then accept and score the sample.
    task automatic drain(input int hold);
        exp_t e;
        logic bad;
        bad = 1'b0;
        e = sb_q[0];
        for (int i = 0; i < hold; i++) begin
            if (!bus.out_valid || bus.out_data != e.data || bus.out_channel != e.ch ||
                bus.out_timestamp != e.ts || timeout_err)
                bad = 1'b1;
            tick();
        end
        chk("hold_stable", 64'(bad), 64'd0);
        bus.out_ready = 1'b1;
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        e = sb_q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e.data));
        chk("out_channel", 64'(bus.out_channel), 64'(e.ch));
        chk("out_timestamp", 64'(bus.out_timestamp), 64'(e.ts));
        tick();
        bus.out_ready = 1'b0;
        chk("valid_drop", 64'(bus.out_valid), 64'd0);
        chk("req_ready_back", 64'(bus.req_ready), 64'd1);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Grant that never gets a done: expect one timeout pulse after 64 cycles.
    task automatic timeout_grant(input logic [CW-1:0] ch);
        logic bad;
        bad = 1'b0;
        grant_start(ch);
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (timeout_err || bus.out_valid) bad = 1'b1;
        end
        tick();
        chk("to_early_or_valid", 64'(bad), 64'd0);
        chk("to_pulse", 64'(timeout_err), 64'd1);
        if (exp_err < 255) exp_err++;
        chk("err_count", 64'(err_count), 64'(exp_err));
        tick();
        chk("to_one_cycle", 64'(timeout_err), 64'd0);
        chk("to_req_ready", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[6];
        logic [TW-1:0] ts;
        logic          bad;

        vecs[0] = '{ch: 4'd5,  delay: 20, data: 12'hA5C, hold: 0};
        vecs[1] = '{ch: 4'd5,  delay: 20, data: 12'hA5C, hold: 30};
        vecs[2] = '{ch: 4'd0,  delay: 1,  data: 12'h000, hold: 0};
        vecs[3] = '{ch: 4'd15, delay: 3,  data: 12'hFFF, hold: 2};
        vecs[4] = '{ch: 4'd3,  delay: 64, data: 12'h123, hold: 1};
        vecs[5] = '{ch: 4'd10, delay: 7,  data: 12'h5A5, hold: 5};

        bus.req_valid   = 1'b0;
        bus.req_channel = '0;
        bus.out_ready   = 1'b0;

        @(negedge clk);
        tick();
        chk("rst_start", 64'(adc_start_conv), 64'd0);
        chk("rst_chsel", 64'(adc_channel_sel), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_ts", 64'(bus.out_timestamp), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_busy", 64'(seq_busy), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

`ifdef ADC_SEQ_AVG_EN
        begin
            logic [AW-1:0] avg_in[4];
            logic [TW-1:0] ts_first;
            avg_in[0] = 12'd100; avg_in[1] = 12'd101; avg_in[2] = 12'd102; avg_in[3] = 12'd105;
            ts_first = '0;
            grant_start(4'd6);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) chk("avg_restart", 64'(adc_start_conv), 64'd1);
                respond(2, avg_in[k], 4'd6, ts);
                if (k == 0) ts_first = ts;
            end
            sb_q.push_back('{data: 12'd102, ch: 4'd6, ts: ts_first});
            drain(0);
        end
`else
        // Table-driven grants through the scoreboard.
        for (int v = 0; v < 6; v++) begin
            grant_start(vecs[v].ch);
            respond(vecs[v].delay, vecs[v].data, vecs[v].ch, ts);
            sb_q.push_back('{data: vecs[v].data, ch: vecs[v].ch, ts: ts});
            chk("no_timeout_err", 64'(err_count), 64'd0);
            drain(vecs[v].hold);
        end

        // Busy ADC, then disabled system: grant must be refused.
        bus.req_valid   = 1'b1;
        bus.req_channel = 4'd8;
        for (int g = 0; g < 2; g++) begin
            bad = 1'b0;
            adc_busy = (g == 0);
            enable   = (g != 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (bus.req_ready || adc_start_conv || seq_busy) bad = 1'b1;
            end
            chk("gated_grant", 64'(bad), 64'd0);
        end
        bus.req_valid = 1'b0;
        adc_busy = 1'b0;
        enable   = 1'b1;
        tick();

        // Dropping enable mid-conversion must not abort the sample.
        grant_start(4'd7);
        enable = 1'b0;
        respond(10, 12'h777, 4'd7, ts);
        sb_q.push_back('{data: 12'h777, ch: 4'd7, ts: ts});
        chk("valid_while_disabled", 64'(bus.out_valid), 64'd1);
        chk("req_ready_disabled", 64'(bus.req_ready), 64'd0);
        enable = 1'b1;
        drain(3);

        // Timeouts, then saturation of the error counter.
        timeout_grant(4'd1);
        for (int r = 0; r < 300; r++) timeout_grant(4'(r));
        chk("err_count_sat", 64'(err_count), 64'd255);

        // Asynchronous reset in the middle of a conversion.
        grant_start(4'd2);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(seq_busy), 64'd0);
        chk("midrst_err_count", 64'(err_count), 64'd0);
        chk("midrst_chsel", 64'(adc_channel_sel), 64'd0);
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 0;
        tick();
        grant_start(4'd12);
        respond(5, 12'h9C3, 4'd12, ts);
        sb_q.push_back('{data: 12'h9C3, ch: 4'd12, ts: ts});
        drain(0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
